// File: rtl/rv32i_types_pkg.sv
// Shared RV32I decode types: opcode encodings, per-instruction field bundle and
// the per-lane record held in the decode stage's output and skid registers.
package rv32i_types;

  localparam int         INSTR_W   = 32;
  localparam int         XLEN      = 32;
  localparam logic [1:0] LEGAL_LOW = 2'b11;

  typedef enum logic [6:0] {
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111,
    OP_JALR  = 7'b1100111,
    OP_BR    = 7'b1100011,
    OP_LOAD  = 7'b0000011,
    OP_STORE = 7'b0100011,
    OP_IMM   = 7'b0010011,
    OP_REG   = 7'b0110011,
    OP_CSR   = 7'b1110011
  } rv32i_opcode;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    rv32i_opcode opcode;
    logic [31:0] i_imm;
    logic [31:0] s_imm;
    logic [31:0] b_imm;
    logic [31:0] u_imm;
    logic [31:0] j_imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } instruction_decoded;

  typedef struct packed {
    instruction_decoded dec;
    logic [XLEN-1:0]    pc;
    logic               valid;
    logic               illegal;
  } decode_lane_t;

  // Stage occupancy; bit 1 is out_valid, bit 0 is skid_valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b10,
    ST_SKID  = 2'b11
  } stage_state_e;

endpackage

// File: rtl/decode_stage_field_extract.sv
// Single-lane RV32I field/immediate extraction and illegal-encoding detection.
module rv32i_field_extract
  import rv32i_types::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               lane_valid,
  output instruction_decoded dec,
  output logic               illegal
);

  logic bad;

  always_comb begin
    dec        = '0;
    dec.funct3 = instr[14:12];
    dec.funct7 = instr[31:25];
    dec.opcode = rv32i_opcode'(instr[6:0]);
    dec.rs1    = instr[19:15];
    dec.rs2    = instr[24:20];
    dec.rd     = instr[11:7];
    dec.i_imm  = {{20{instr[31]}}, instr[31:20]};
    dec.s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    dec.b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    dec.u_imm  = {instr[31:12], 12'b0};
    dec.j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  end

  always_comb begin
    bad = (instr[1:0] != LEGAL_LOW);
    case (instr[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_BR, OP_LOAD, OP_STORE, OP_IMM, OP_CSR: ;
      OP_JALR: if (instr[14:12] != 3'b000) bad = 1'b1;
      OP_REG:  if (instr[31:25] != 7'h00 && instr[31:25] != 7'h20) bad = 1'b1;
      default: bad = 1'b1;
    endcase
    // Masked-off lanes never raise illegal.
    illegal = lane_valid & bad;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane RV32I decode stage with a one-packet skid buffer so
// in_ready comes straight from a flop.
module decode_stage
  import rv32i_types::*;
#(
  parameter int LANES    = 2,
  parameter int PC_WIDTH = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [INSTR_W*LANES-1:0]           in_instr,
  input  logic [PC_WIDTH-1:0]                in_pc,
  input  logic [LANES-1:0]                   in_lane_mask,
  output logic                               out_valid,
  input  logic                               out_ready,
  output instruction_decoded [LANES-1:0]     out_dec,
  output logic [LANES-1:0][PC_WIDTH-1:0]     out_pc,
  output logic [LANES-1:0]                   out_lane_valid,
  output logic [LANES-1:0]                   out_illegal
);

  decode_lane_t [LANES-1:0] lane_in;
  decode_lane_t [LANES-1:0] out_q, out_d, skid_q, skid_d;
  stage_state_e             state_q, state_d;
  logic                     load;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    instruction_decoded  dec;
    logic                illegal;
    logic [PC_WIDTH-1:0] pc_lane;

    rv32i_field_extract u_extract (
      .instr      (in_instr[INSTR_W*i +: INSTR_W]),
      .lane_valid (in_lane_mask[i]),
      .dec        (dec),
      .illegal    (illegal)
    );

    assign pc_lane    = in_pc + PC_WIDTH'(4 * i);
    assign lane_in[i] = '{dec: dec, pc: XLEN'(pc_lane), valid: in_lane_mask[i], illegal: illegal};

    assign out_dec[i]        = out_q[i].dec;
    assign out_pc[i]         = out_q[i].pc[PC_WIDTH-1:0];
    assign out_lane_valid[i] = out_q[i].valid;
    assign out_illegal[i]    = out_q[i].illegal;
  end

  assign out_valid = state_q[1];
  assign in_ready  = !state_q[0];

  // Empty-mask packets are consumed upstream but never occupy a register.
  assign load = in_valid && in_ready && !flush && (|in_lane_mask);

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (load) begin
            out_d   = lane_in;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (out_ready) begin
            if (load) out_d = lane_in;
            else      state_d = ST_EMPTY;
          end else if (load) begin
            skid_d  = lane_in;
            state_d = ST_SKID;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            out_d   = skid_q;
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, illegal flags, skid ordering,
// flush, PC wrap, empty-mask packets, streaming order and async reset.
module tb_decode_stage;
  import rv32i_types::*;

  localparam int LANES    = 2;
  localparam int PC_WIDTH = 32;

  logic                           clk;
  logic                           rst_n;
  logic                           flush;
  logic                           in_valid;
  logic                           in_ready;
  logic [INSTR_W*LANES-1:0]       in_instr;
  logic [PC_WIDTH-1:0]            in_pc;
  logic [LANES-1:0]               in_lane_mask;
  logic                           out_valid;
  logic                           out_ready;
  instruction_decoded [LANES-1:0] out_dec;
  logic [LANES-1:0][PC_WIDTH-1:0] out_pc;
  logic [LANES-1:0]               out_lane_valid;
  logic [LANES-1:0]               out_illegal;

  int n_checks = 0;
  int n_pass   = 0;

  decode_stage #(.LANES(LANES), .PC_WIDTH(PC_WIDTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_instr       (in_instr),
    .in_pc          (in_pc),
    .in_lane_mask   (in_lane_mask),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_dec        (out_dec),
    .out_pc         (out_pc),
    .out_lane_valid (out_lane_valid),
    .out_illegal    (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i1, input logic [31:0] i0,
                       input logic [31:0] pc, input logic [1:0] mask);
    in_instr     = {i1, i0};
    in_pc        = pc;
    in_lane_mask = mask;
    in_valid     = 1'b1;
  endtask

  function automatic logic [31:0] make_addi(input logic [4:0] rd, input logic [11:0] imm);
    return {imm, 5'd0, 3'd0, rd, 7'h13};
  endfunction

  logic [15:0] rdy_pat;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc;
  int          sent;
  int          got;

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_lane_mask = '0;
    tick(); tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_lane_valid", 32'(out_lane_valid), 32'd0);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    check("rst_pc1", out_pc[1], 32'd0);
    check("rst_opcode0", 32'(out_dec[0].opcode), 32'd0);
    check("rst_imm0", out_dec[0].i_imm, 32'd0);
    rst_n = 1'b1;

    // Basic addi pair
    drive(32'hFFF00093, 32'h00500093, 32'h100, 2'b11);
    tick();
    in_valid = 1'b0;
    check("t1_out_valid", 32'(out_valid), 32'd1);
    check("t1_rd0", 32'(out_dec[0].rd), 32'd1);
    check("t1_rs1_0", 32'(out_dec[0].rs1), 32'd0);
    check("t1_iimm0", out_dec[0].i_imm, 32'd5);
    check("t1_pc0", out_pc[0], 32'h100);
    check("t1_iimm1", out_dec[1].i_imm, 32'hFFFFFFFF);
    check("t1_pc1", out_pc[1], 32'h104);
    check("t1_illegal", 32'(out_illegal), 32'd0);
    check("t1_lane_valid", 32'(out_lane_valid), 32'd3);

    drive(32'h00000000, 32'h00008067, 32'h200, 2'b11);
    tick();
    check("jalr_illegal", 32'(out_illegal), 32'b10);
    check("jalr_opcode", 32'(out_dec[0].opcode), 32'h67);
    check("jalr_rs1", 32'(out_dec[0].rs1), 32'd1);

    drive(32'h00000013, 32'h00009067, 32'h200, 2'b11);
    tick();
    check("jalr_f3_illegal", 32'(out_illegal), 32'b01);
    check("jalr_f3", 32'(out_dec[0].funct3), 32'd1);

    drive(32'h02000033, 32'h40000033, 32'h200, 2'b11);
    tick();
    check("reg_f7_illegal", 32'(out_illegal), 32'b10);
    check("reg_f7_lane0", 32'(out_dec[0].funct7), 32'h20);

    drive(32'h00000000, 32'h00000013, 32'h200, 2'b01);
    tick();
    check("masked_illegal", 32'(out_illegal), 32'b00);
    check("masked_lane_valid", 32'(out_lane_valid), 32'b01);

    drive(32'h80000063, 32'hFE000FA3, 32'h200, 2'b11);
    tick();
    check("s_imm", out_dec[0].s_imm, 32'hFFFFFFFF);
    check("b_imm", out_dec[1].b_imm, 32'hFFFFF000);
    check("sb_illegal", 32'(out_illegal), 32'b00);

    drive(32'h8000006F, 32'h12345037, 32'h200, 2'b11);
    tick();
    check("u_imm", out_dec[0].u_imm, 32'h12345000);
    check("j_imm", out_dec[1].j_imm, 32'hFFF00000);
    check("uj_illegal", 32'(out_illegal), 32'b00);

    // Drain, then fill output and skid with back-pressure
    in_valid = 1'b0;
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(32'h0, make_addi(5'd2, 12'd2), 32'h200, 2'b11);
    tick();
    check("skA_in_ready", 32'(in_ready), 32'd1);
    drive(32'h0, make_addi(5'd3, 12'd3), 32'h300, 2'b11);
    tick();
    check("skB_in_ready", 32'(in_ready), 32'd0);
    check("skB_out_pc", out_pc[0], 32'h200);
    drive(32'h0, make_addi(5'd4, 12'd4), 32'h400, 2'b11);
    tick();
    check("skC_hold_pc", out_pc[0], 32'h200);
    check("skC_hold_rd", 32'(out_dec[0].rd), 32'd2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("skB_out_valid", 32'(out_valid), 32'd1);
    check("skB_out_pc2", out_pc[0], 32'h300);
    check("skB_rd", 32'(out_dec[0].rd), 32'd3);
    check("skB_in_ready2", 32'(in_ready), 32'd1);
    tick();
    check("sk_empty", 32'(out_valid), 32'd0);

    // Flush while in SKID
    out_ready = 1'b0;
    drive(32'h0, make_addi(5'd5, 12'd5), 32'h500, 2'b11);
    tick();
    drive(32'h0, make_addi(5'd6, 12'd6), 32'h600, 2'b11);
    tick();
    check("fl_skid_ready", 32'(in_ready), 32'd0);
    drive(32'h0, make_addi(5'd7, 12'd7), 32'h700, 2'b11);
    flush = 1'b1;
    out_ready = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("fl_nothing_later", 32'(out_valid), 32'd0);

    // Flush in EMPTY drops the offered packet
    drive(32'h0, make_addi(5'd8, 12'd8), 32'h800, 2'b11);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check("fl_empty_drop", 32'(out_valid), 32'd0);

    // PC wrap
    drive(32'h00000013, 32'h00000013, 32'hFFFFFFFC, 2'b11);
    tick();
    in_valid = 1'b0;
    check("wrap_pc0", out_pc[0], 32'hFFFFFFFC);
    check("wrap_pc1", out_pc[1], 32'h00000000);
    tick();

    // Empty-mask packets: consumed, no output, no skid
    drive(32'h00000013, 32'h00000013, 32'h900, 2'b00);
    tick();
    in_valid = 1'b0;
    check("mask0_empty", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    drive(32'h0, make_addi(5'd9, 12'd9), 32'hA00, 2'b11);
    tick();
    drive(32'h00000013, 32'h00000013, 32'hB00, 2'b00);
    tick();
    in_valid = 1'b0;
    check("mask0_full_ready", 32'(in_ready), 32'd1);
    check("mask0_full_pc", out_pc[0], 32'hA00);
    out_ready = 1'b1;
    tick();
    check("mask0_drained", 32'(out_valid), 32'd0);

    // Streaming with a fixed back-pressure pattern
    rdy_pat = 16'b1011_0010_1110_0110;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 200 && got < 12; cyc++) begin
      if (sent < 12) drive(32'h0, make_addi(5'(sent + 1), 12'(sent)), 32'h1000 + 32'(sent) * 16, 2'b11);
      else           in_valid = 1'b0;
      out_ready = rdy_pat[cyc % 16];
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'd1, 32'd0);
        end else begin
          exp_pc = exp_q.pop_front();
          check("stream_pc", out_pc[0], exp_pc);
          check("stream_rd", 32'(out_dec[0].rd), ((exp_pc - 32'h1000) >> 4) + 32'd1);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_pc);
        sent++;
      end
      tick();
    end
    in_valid = 1'b0;
    check("stream_count", 32'(got), 32'd12);

    // Async reset while FULL clears outputs before the next edge
    out_ready = 1'b0;
    drive(32'h0, make_addi(5'd10, 12'd10), 32'hC00, 2'b11);
    tick();
    in_valid = 1'b0;
    check("ar_full", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ar_out_valid", 32'(out_valid), 32'd0);
    check("ar_pc0", out_pc[0], 32'd0);
    check("ar_lane_valid", 32'(out_lane_valid), 32'd0);
    check("ar_in_ready", 32'(in_ready), 32'd1);
    tick();
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
